// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order IMEM request channel, instruction buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise a sticky flag.
module fetch_unit #(
  parameter int unsigned        DWIDTH    = 64,
  parameter int unsigned        IWIDTH    = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned        BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [IWIDTH-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_target,
  output logic              inst_valid,
  output logic [DWIDTH-1:0] inst,
  output logic [DWIDTH-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              misaligned
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthSum = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [PW-1:0]     buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic              misaligned_q, misaligned_d;

  logic [DWIDTH-1:0] aq_mem   [BUF_DEPTH];
  logic [IWIDTH-1:0] buf_word [BUF_DEPTH];
  logic [DWIDTH-1:0] buf_pc   [BUF_DEPTH];

  logic              redir, bad_align, credit_ok, accept, keep, pop;
  logic [DWIDTH-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_align = |redirect_target[1:0];
  assign target    = redirect_target;
`else
  logic unused_lowbits;
  assign unused_lowbits = ^redirect_target[1:0];
  assign bad_align      = 1'b0;
  assign target         = {redirect_target[DWIDTH-1:2], 2'b00};
`endif

  // Redirects are ignored during the single IDLE cycle after reset.
  assign redir     = redirect_valid && (state_q != StIdle);
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < DepthSum;

  assign imem_req_valid = (state_q == StFetch) && credit_ok && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  // A response is kept only when nothing stale is outstanding and no flush is happening.
  assign keep           = imem_rsp_valid && (drop_q == '0) && !redir;

  assign inst_valid = (count_q != '0) && !redir;
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? DWIDTH'(buf_word[buf_rd_q]) : '0;
  assign inst_pc    = inst_valid ? buf_pc[buf_rd_q] : '0;
  assign misaligned = misaligned_q;

  always_comb begin
    state_d      = state_q;
    misaligned_d = misaligned_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d       = drop_q;
    count_d      = count_q + CW'(keep) - CW'(pop);
    aq_rd_d      = aq_rd_q + PW'(keep);
    aq_wr_d      = aq_wr_q + PW'(accept);
    buf_rd_d     = buf_rd_q + PW'(pop);
    buf_wr_d     = buf_wr_q + PW'(keep);

    if (accept) pc_d = pc_q + DWIDTH'(4);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);

    if (redir) begin
      pc_d         = target;
      // Everything still outstanding after this cycle's response is stale.
      drop_d       = inflight_q - CW'(imem_rsp_valid);
      count_d      = '0;
      aq_rd_d      = '0;
      aq_wr_d      = '0;
      buf_rd_d     = '0;
      buf_wr_d     = '0;
      misaligned_d = bad_align;
    end

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (redir && bad_align) state_d = StHalt;
      StHalt:  if (redir && !bad_align) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      aq_rd_q      <= '0;
      aq_wr_q      <= '0;
      buf_rd_q     <= '0;
      buf_wr_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      aq_rd_q      <= aq_rd_d;
      aq_wr_q      <= aq_wr_d;
      buf_rd_q     <= buf_rd_d;
      buf_wr_q     <= buf_wr_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (accept) aq_mem[aq_wr_q] <= pc_q;
    if (keep) begin
      buf_word[buf_wr_q] <= imem_rsp_data;
      buf_pc[buf_wr_q]   <= aq_mem[aq_rd_q];
    end
  end

endmodule
